// File: rtl/hazard_ctrl.sv
// hazard_ctrl: keeps shadow records of the instructions in EX/MEM/WB and
// drives the stall, flush and forwarding controls of the pipeline.
// Also counts hazard stall cycles, saturating, for performance debug.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                      rs1_used_ID,
    input  logic                      rs2_used_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
    input  logic                      reg_write_ID,
    input  logic [1:0]                result_sel_ID,
    input  logic                      redirect_EX,
    input  logic                      mem_ready,
    input  logic                      stall_cnt_clr,
    output logic                      stall_IF,
    output logic                      stall_ID,
    output logic                      flush_ID,
    output logic                      flush_EX,
    output logic [1:0]                fwd_sel_0_EX,
    output logic [1:0]                fwd_sel_1_EX,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    // EX record; only EX needs is_load (load-use) and the source fields (forwarding)
    logic                      ex_valid_q, ex_rw_q, ex_ld_q, ex_u1_q, ex_u2_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic                      ex_valid_d;
    // MEM/WB records only act as forwarding sources
    logic                      mem_valid_q, mem_rw_q, wb_valid_q, wb_rw_q;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q, wb_rd_q;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic ex_wr, mem_wr, wb_wr, load_use, count_en;

    // x0 is hardwired zero, so it never produces a hazard or forward
    assign ex_wr  = ex_valid_q  && ex_rw_q  && (ex_rd_q  != '0);
    assign mem_wr = mem_valid_q && mem_rw_q && (mem_rd_q != '0);
    assign wb_wr  = wb_valid_q  && wb_rw_q  && (wb_rd_q  != '0);

    assign load_use = ex_wr && ex_ld_q && id_valid &&
                      ((rs1_used_ID && (rs1_ID == ex_rd_q)) ||
                       (rs2_used_ID && (rs2_ID == ex_rd_q)));

    // stall/flush priority: freeze > redirect > load-use
    always_comb begin
        stall_IF = 1'b0;
        stall_ID = 1'b0;
        flush_ID = 1'b0;
        flush_EX = 1'b0;
        count_en = 1'b0;
        if (!mem_ready) begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            count_en = 1'b1;
        end else if (redirect_EX) begin
            flush_ID = 1'b1;
            flush_EX = 1'b1;
        end else if (load_use) begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            flush_EX = 1'b1;
            count_en = 1'b1;
        end
    end

    // operand forwarding: the younger MEM result wins over WB
    always_comb begin
        fwd_sel_0_EX = 2'b00;
        fwd_sel_1_EX = 2'b00;
        if (ex_valid_q && ex_u1_q) begin
            if (mem_wr && (mem_rd_q == ex_rs1_q))     fwd_sel_0_EX = 2'b10;
            else if (wb_wr && (wb_rd_q == ex_rs1_q))  fwd_sel_0_EX = 2'b01;
        end
        if (ex_valid_q && ex_u2_q) begin
            if (mem_wr && (mem_rd_q == ex_rs2_q))     fwd_sel_1_EX = 2'b10;
            else if (wb_wr && (wb_rd_q == ex_rs2_q))  fwd_sel_1_EX = 2'b01;
        end
    end

    assign ex_valid_d = id_valid && !flush_EX;

    // shadow pipeline advances only when memory lets the pipeline move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_u1_q     <= 1'b0;
            ex_u2_q     <= 1'b0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
        end else if (mem_ready) begin
            wb_valid_q  <= mem_valid_q;
            wb_rw_q     <= mem_rw_q;
            wb_rd_q     <= mem_rd_q;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_rd_q    <= ex_rd_q;
            // a bubble carries no write, load or source usage
            ex_valid_q  <= ex_valid_d;
            ex_rw_q     <= ex_valid_d && reg_write_ID;
            ex_ld_q     <= ex_valid_d && (result_sel_ID == 2'b01);
            ex_u1_q     <= ex_valid_d && rs1_used_ID;
            ex_u2_q     <= ex_valid_d && rs2_used_ID;
            ex_rd_q     <= rd_ID;
            ex_rs1_q    <= rs1_ID;
            ex_rs2_q    <= rs2_ID;
        end
    end

    // saturating stall counter; clear beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (stall_cnt_clr)           cnt_d = '0;
        else if (count_en && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    // stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller sitting beside the ID stage. It consumes decoded ID fields (rs1/rs2/rd, reg_write, result_sel) plus EX redirect and data-memory ready.
- Keeps a shadow record of instructions in EX/MEM/WB.
- Drives stall, flush and forwarding selects for the IF/ID and ID/EX pipeline registers and the EX operand muxes.
- Counts hazard stall cycles for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 16, stall counter width (saturating)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- rs1_ID  in  REG_ADDR_WIDTH  source 1 index in ID
- rs2_ID  in  REG_ADDR_WIDTH  source 2 index in ID
- rs1_used_ID  in  1  instruction reads rs1
- rs2_used_ID  in  1  instruction reads rs2
- rd_ID  in  REG_ADDR_WIDTH  destination index in ID
- reg_write_ID  in  1  instruction writes rd
- result_sel_ID  in  2  00 ALU, 01 memory load, 10 PC+4, 11 reserved (treated as ALU)
- redirect_EX  in  1  taken branch/jump resolved in EX this cycle
- mem_ready  in  1  data memory can complete this cycle; 0 freezes pipeline
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- stall_IF  out  1  hold PC
- stall_ID  out  1  hold IF/ID register
- flush_ID  out  1  zero IF/ID register (insert NOP)
- flush_EX  out  1  load bubble into ID/EX register
- fwd_sel_0_EX  out  2  EX operand 0 source: 00 regfile, 01 WB result, 10 MEM result
- fwd_sel_1_EX  out  2  same for operand 1
- stall_cnt  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Shadow state: three stage records EX, MEM, WB, each {valid, rd, reg_write, is_load}. EX additionally holds rs1, rs2, rs1_used, rs2_used.
- is_load = (result_sel_ID == 01).
- A record "writes" when valid && reg_write && rd != 0. x0 is never a hazard or forward source.
- Reset (async, rst=1): all records invalid, stall_cnt=0. All control outputs are 0 because they are derived from invalid records, except where redirect_EX or mem_ready drive them directly.
- Freeze (mem_ready=0) has highest priority:
  - stall_IF=stall_ID=1, flush_ID=flush_EX=0.
  - Shadow records hold.
  - stall_cnt increments.
  - EX holds redirect_EX stable until release; flushes act on the first mem_ready=1 cycle.
- Redirect (mem_ready=1, redirect_EX=1):
  - flush_ID=1, flush_EX=1, stall_IF=stall_ID=0.
  - The load-use check is ignored (wrong-path instruction).
- Load-use (mem_ready=1, redirect_EX=0):
  - Condition: EX record writes && is_load && id_valid && ((rs1_used_ID && rs1_ID==rd_EX) || (rs2_used_ID && rs2_ID==rd_EX)).
  - Response: stall_IF=stall_ID=1, flush_EX=1, flush_ID=0, stall_cnt increments.
  - Lasts exactly one cycle, because the load advances to MEM.
- Otherwise all stall/flush outputs are 0.
- Shadow advance on every clk edge with mem_ready=1: WB<=MEM, MEM<=EX, and EX<=ID fields.
  - EX valid = id_valid && !flush_EX.
  - A bubble clears valid and reg_write.
- Forwarding is combinational from the shadow regs, per operand n with source rsn_EX:
  - If EX record rsn_used and MEM writes with rd==rsn_EX -> 10.
  - Else if WB writes with rd==rsn_EX -> 01.
  - Else 00.
  - MEM beats WB when both match. Selects are 00 when the EX record is invalid.
- Regfile is write-first, so no WB->ID forwarding is needed.
- stall_cnt: +1 per freeze or load-use cycle and saturates at all-ones.
  - stall_cnt_clr has priority over increment (result 0).
  - Redirect cycles are not counted.

Test Plan:
- Reset mid-run: drive a load-use case, assert rst asynchronously mid-cycle -> all outputs 0 immediately, stall_cnt=0, no stall after release until new hazard.
- lw x5 then add x6,x5,x7 back-to-back -> one cycle stall_IF=stall_ID=flush_EX=1, then fwd_sel_0_EX=01 (WB) when the add is in EX; stall_cnt=1.
- add x3,x1,x2; sub x4,x3,x3 -> no stall; both fwd_sel = 10. The same producer with one independent instruction between -> both fwd_sel=01.
- Producer rd=x0 followed by consumer of x0 -> no stall, fwd_sel=00.
- Load-use coincident with redirect_EX=1 -> flush_ID=flush_EX=1, stall_IF=0, stall_cnt unchanged.
- mem_ready=0 for 3 cycles with pending redirect -> stalls held, no flush, stall_cnt +3. On release -> flush_ID=flush_EX=1 for one cycle. Preload stall_cnt near all-ones -> saturates, and clr yields 0.
